axi_lite_sram: RTL and testbench

AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

---
 rtl/axi_lite_sram_if.sv | 34 +++
 rtl/axi_lite_sram.sv | 195 +++++++++++++++++++
 tb/tb_axi_lite_sram.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_if.sv
// AXI-Lite style bus between a master and the axi_lite_sram slave.
// Five independent valid/ready channels: aw, w, b, ar, r.
interface axi_lite_sram_if #(
    parameter int DATA_LEN     = 32,
    parameter int DATA_BIT_NUM = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [DATA_LEN-1:0]     waddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_LEN-1:0]     wdata;
    logic [DATA_BIT_NUM-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [2:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_LEN-1:0]     raddr;
    logic                    rvalid;
    logic                    rready;
    logic [2:0]              rresp;
    logic [DATA_LEN-1:0]     rdata;

    modport master (
        output awvalid, waddr, wvalid, wdata, wstrb, bready, arvalid, raddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport slave (
        input  awvalid, waddr, wvalid, wdata, wstrb, bready, arvalid, raddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI-Lite SRAM slave: byte-strobed word memory with independent read and write paths.
// Optional SRAM_RAND_DELAY_EN adds 0-3 cycles of LFSR-driven response delay.
module axi_lite_sram #(
    parameter int                  DATA_LEN     = 32,
    parameter int                  DATA_BIT_NUM = 4,
    parameter int                  MEM_WORDS    = 1024,
    parameter logic [DATA_LEN-1:0] BASE_ADDR    = 32'h8000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    axi_lite_sram_if.slave bus
);
    localparam int             AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int             EW          = DATA_LEN + 1;
    localparam logic [EW-1:0]  TOP_ADDR    = {1'b0, BASE_ADDR} + EW'(4 * MEM_WORDS);
    localparam logic [2:0]     RESP_OKAY   = 3'b000;
    localparam logic [2:0]     RESP_SLVERR = 3'b010;

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_VALID} r_state_t;

    logic [1:0] delay;

`ifdef SRAM_RAND_DELAY_EN
    logic [3:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 4'b1001;
        else        lfsr_q <= lfsr_d;
    end

    assign delay = lfsr_q[1:0];
`else
    assign delay = 2'd0;
`endif

    // ---------------- read path ----------------
    r_state_t            r_state_q, r_state_d;
    logic [1:0]          r_cnt_q, r_cnt_d;
    logic [DATA_LEN-1:0] rdata_q, rdata_d;
    logic [2:0]          rresp_q, rresp_d;
    logic                arready, rvalid, ar_hs, rd_ok;
    logic [AW-1:0]       ridx;
    logic [DATA_LEN-1:0] rd_word;

    assign ar_hs = bus.arvalid & arready;
    assign rd_ok = (bus.raddr >= BASE_ADDR) && ({1'b0, bus.raddr} < TOP_ADDR);
    assign ridx  = AW'((bus.raddr - BASE_ADDR) >> 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state_q <= R_IDLE;
        else        r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: if (bus.arvalid) begin
                r_cnt_d   = delay;
                r_state_d = (delay != 2'd0) ? R_DELAY : R_VALID;
            end
            R_DELAY: begin
                r_cnt_d = r_cnt_q - 2'd1;
                if (r_cnt_q == 2'd1) r_state_d = R_VALID;
            end
            R_VALID: if (bus.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_VALID);
    end

    // Data is captured on the handshake edge, so a same-cycle write is not yet visible.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            rdata_d = rd_ok ? rd_word : '0;
            rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- write path ----------------
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                    resp_pending_q, resp_pending_d, bvalid_q, bvalid_d;
    logic [DATA_LEN-1:0]     waddr_q, waddr_d, wdata_q, wdata_d;
    logic [DATA_BIT_NUM-1:0] wstrb_q, wstrb_d;
    logic [2:0]              bresp_q, bresp_d;
    logic [1:0]              b_cnt_q, b_cnt_d;
    logic                    awready, wready, aw_hs, w_hs, commit, wr_ok;
    logic [DATA_LEN-1:0]     waddr_c, wdata_c;
    logic [DATA_BIT_NUM-1:0] wstrb_c;
    logic [AW-1:0]           widx;

    assign awready = ~aw_held_q & ~resp_pending_q;
    assign wready  = ~w_held_q & ~resp_pending_q;
    assign aw_hs   = bus.awvalid & awready;
    assign w_hs    = bus.wvalid & wready;
    assign commit  = (aw_hs | aw_held_q) & (w_hs | w_held_q);
    assign waddr_c = aw_held_q ? waddr_q : bus.waddr;
    assign wdata_c = w_held_q ? wdata_q : bus.wdata;
    assign wstrb_c = w_held_q ? wstrb_q : bus.wstrb;
    assign wr_ok   = (waddr_c >= BASE_ADDR) && ({1'b0, waddr_c} < TOP_ADDR);
    assign widx    = AW'((waddr_c - BASE_ADDR) >> 2);

    always_comb begin
        aw_held_d      = aw_held_q;
        w_held_d       = w_held_q;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        resp_pending_d = resp_pending_q;
        bvalid_d       = bvalid_q;
        bresp_d        = bresp_q;
        b_cnt_d        = b_cnt_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            waddr_d   = bus.waddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = bus.wdata;
            wstrb_d  = bus.wstrb;
        end
        if (commit) begin
            aw_held_d      = 1'b0;
            w_held_d       = 1'b0;
            resp_pending_d = 1'b1;
            bresp_d        = wr_ok ? RESP_OKAY : RESP_SLVERR;
            b_cnt_d        = delay;
            bvalid_d       = (delay == 2'd0);
        end else if (resp_pending_q && !bvalid_q) begin
            b_cnt_d = b_cnt_q - 2'd1;
            if (b_cnt_q == 2'd1) bvalid_d = 1'b1;
        end else if (bvalid_q && bus.bready) begin
            bvalid_d       = 1'b0;
            resp_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q        <= 2'd0;
            rdata_q        <= '0;
            rresp_q        <= 3'b000;
            aw_held_q      <= 1'b0;
            w_held_q       <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            resp_pending_q <= 1'b0;
            bvalid_q       <= 1'b0;
            bresp_q        <= 3'b000;
            b_cnt_q        <= 2'd0;
        end else begin
            r_cnt_q        <= r_cnt_d;
            rdata_q        <= rdata_d;
            rresp_q        <= rresp_d;
            aw_held_q      <= aw_held_d;
            w_held_q       <= w_held_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            resp_pending_q <= resp_pending_d;
            bvalid_q       <= bvalid_d;
            bresp_q        <= bresp_d;
            b_cnt_q        <= b_cnt_d;
        end
    end

    // One RAM per byte lane keeps strobed writes free of read-modify-write.
    for (genvar gi = 0; gi < DATA_BIT_NUM; gi++) begin : g_lane
        logic [7:0] mem [MEM_WORDS];

        always_ff @(posedge clk) begin
            if (commit && wr_ok && wstrb_c[gi]) mem[widx] <= wdata_c[gi*8 +: 8];
        end

        assign rd_word[gi*8 +: 8] = mem[ridx];
    end

    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_lite_sram.sv
// Randomized self-checking bench for axi_lite_sram against an array model of the memory.
// Latency checks widen to 1-4 cycles when SRAM_RAND_DELAY_EN is defined.
module tb_axi_lite_sram;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h8000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [MEM_WORDS];
    logic [31:0] oor [8] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h0000_0000, 32'hFFFF_FFFC,
                             32'h7FFF_FFFF, 32'h8000_1003, 32'h8001_0000, 32'h1234_5678};

    always #5 clk = ~clk;

    axi_lite_sram_if #(.DATA_LEN(32), .DATA_BIT_NUM(4)) bus ();

    axi_lite_sram #(
        .DATA_LEN(32), .DATA_BIT_NUM(4), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * MEM_WORDS)));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2) % MEM_WORDS;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat);
`ifdef SRAM_RAND_DELAY_EN
        chk(tag, 64'(lat >= 1 && lat <= 4), 64'd1);
`else
        chk(tag, 64'(lat), 64'd1);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_rvalid"}, 64'(bus.rvalid), 64'd0);
        chk({tag, "_rst_bvalid"}, 64'(bus.bvalid), 64'd0);
        chk({tag, "_rst_rdata"}, 64'(bus.rdata), 64'd0);
        chk({tag, "_rst_resp"}, 64'({bus.rresp, bus.bresp}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_ready"}, 64'({bus.arready, bus.awready, bus.wready}), 64'b111);
        $display("[TB] reset %s", tag);
    endtask

    // aw is offered from cycle aw_at, w from cycle w_at; bready is withheld for bhold cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_at, input int w_at, input int bhold, input string tag);
        int         cyc, lat;
        bit         aw_done, w_done, hs_aw, hs_w;
        logic [2:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_resp = in_rng(addr) ? 3'b000 : 3'b010;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (aw_done) chk({tag, "_awready_low"}, 64'(bus.awready), 64'd0);
            if (w_done)  chk({tag, "_wready_low"}, 64'(bus.wready), 64'd0);
            bus.waddr   = aw_done ? $urandom : addr;
            bus.wdata   = w_done ? $urandom : data;
            bus.wstrb   = w_done ? 4'($urandom) : strb;
            bus.awvalid = !aw_done && cyc >= aw_at;
            bus.wvalid  = !w_done && cyc >= w_at;
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            @(posedge clk);
            aw_done |= hs_aw;
            w_done  |= hs_w;
            @(negedge clk);
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk({tag, "_w_accept"}, 64'(aw_done && w_done), 64'd1);
        if (!(aw_done && w_done)) return;
        if (in_rng(addr))
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[widx(addr)][i*8 +: 8] = data[i*8 +: 8];
        lat = 1;
        while (!bus.bvalid && lat < 10) begin
            tick();
            lat++;
        end
        chk_lat({tag, "_blat"}, lat);
        chk({tag, "_bresp"}, 64'(bus.bresp), 64'(exp_resp));
        for (int i = 0; i < bhold; i++) begin
            bus.bready = 1'b0;
            tick();
            chk({tag, "_bhold"}, 64'({bus.bvalid, bus.bresp, bus.awready, bus.wready}),
                64'({1'b1, exp_resp, 2'b00}));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk({tag, "_b_done"}, 64'({bus.bvalid, bus.awready, bus.wready}), 64'b011);
        $display("[TB] write %s addr=%08h data=%08h strb=%h aw@%0d w@%0d resp=%0d lat=%0d",
                 tag, addr, data, strb, aw_at, w_at, bus.bresp, lat);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rhold, input string tag);
        int          cyc, lat;
        bit          done;
        logic [31:0] exp_d;
        logic [2:0]  exp_r;
        exp_r = in_rng(addr) ? 3'b000 : 3'b010;
        exp_d = in_rng(addr) ? model[widx(addr)] : 32'h0;
        done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            bus.raddr   = addr;
            bus.arvalid = 1'b1;
            done = bus.arready;
            tick();
            cyc++;
        end
        bus.arvalid = 1'b0;
        bus.raddr   = $urandom;
        chk({tag, "_ar_accept"}, 64'(done), 64'd1);
        if (!done) return;
        lat = 1;
        while (!bus.rvalid && lat < 10) begin
            chk({tag, "_arready_wait"}, 64'(bus.arready), 64'd0);
            tick();
            lat++;
        end
        chk_lat({tag, "_rlat"}, lat);
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'(exp_d));
        chk({tag, "_rresp"}, 64'(bus.rresp), 64'(exp_r));
        for (int i = 0; i < rhold; i++) begin
            bus.rready = 1'b0;
            chk({tag, "_arready_hold"}, 64'(bus.arready), 64'd0);
            tick();
            chk({tag, "_rhold"}, 64'({bus.rvalid, bus.rresp, bus.rdata}), 64'({1'b1, exp_r, exp_d}));
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk({tag, "_r_done"}, 64'({bus.rvalid, bus.arready}), 64'b01);
        $display("[TB] read  %s addr=%08h data=%08h resp=%0d lat=%0d",
                 tag, addr, bus.rdata, bus.rresp, lat);
    endtask

    initial begin
        int          lat;
        logic [31:0] old_w, new_w, a;
        int          k;
        bus.awvalid = 0; bus.waddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready  = 0; bus.arvalid = 0; bus.raddr = 0; bus.rready = 0;
        do_reset("init");

        for (int i = 0; i < 32; i++) begin
            k = (i < 16) ? i : 992 + i;
            do_write(BASE + 32'(4 * k), $urandom, 4'hF, 0, 0, 0, "fill");
        end

        do_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "full_word");
        do_read(32'h8000_0004, 0, "full_word");
        chk("full_word_model", 64'(model[1]), 64'h0000_0000_DEAD_BEEF);
        do_write(32'h8000_0004, 32'h0000_AB00, 4'b0010, 0, 0, 0, "byte1");
        do_read(32'h8000_0004, 0, "byte1");
        chk("byte1_model", 64'(model[1]), 64'h0000_0000_DEAD_ABEF);
        do_write(32'h8000_000C, 32'h1357_9BDF, 4'hF, 0, 3, 2, "aw_then_w");
        do_write(32'h8000_0010, 32'h2468_ACE0, 4'hF, 2, 0, 1, "w_then_aw");
        do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, "strb0");
        do_read(32'h8000_0010, 0, "strb0");
        do_read(32'h7FFF_FFFC, 0, "oor_low");
        do_write(32'h8000_1000, 32'hBAD0_BAD0, 4'hF, 0, 0, 0, "oor_high");
        do_read(32'h8000_0000, 0, "oor_alias");
        do_read(32'h8000_0FFC, 0, "top_word");
        do_read(32'h8000_0008, 3, "rhold");

        // Read and write of the same word in one cycle: the read sees the old data.
        old_w = model[5];
        new_w = ~old_w;
        bus.raddr = BASE + 32'd20; bus.waddr = BASE + 32'd20; bus.wdata = new_w; bus.wstrb = 4'hF;
        chk("rw_same_ready", 64'({bus.arready, bus.awready, bus.wready}), 64'b111);
        bus.arvalid = 1; bus.awvalid = 1; bus.wvalid = 1;
        tick();
        bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
        lat = 1;
        while (!bus.rvalid && lat < 10) begin tick(); lat++; end
        chk_lat("rw_same_rlat", lat);
        chk("rw_same_rdata", 64'(bus.rdata), 64'(old_w));
        bus.rready = 1;
        lat = 1;
        while (!bus.bvalid && lat < 10) begin tick(); lat++; end
        chk("rw_same_bvalid", 64'(bus.bvalid), 64'd1);
        bus.bready = 1;
        tick();
        bus.rready = 0; bus.bready = 0;
        model[5] = new_w;
        $display("[TB] rw_same word 5 old=%08h new=%08h", old_w, new_w);
        do_read(BASE + 32'd20, 0, "rw_same_after");

        // Reset between the aw and w handshakes: the orphaned w must never commit.
        bus.waddr = BASE + 32'd8;
        bus.awvalid = 1;
        chk("abort_awready", 64'(bus.awready), 64'd1);
        tick();
        bus.awvalid = 0;
        do_reset("abort");
        bus.wdata = ~model[2]; bus.wstrb = 4'hF; bus.wvalid = 1;
        chk("abort_wready", 64'(bus.wready), 64'd1);
        tick();
        bus.wvalid = 0;
        repeat (5) tick();
        chk("abort_no_commit", 64'({bus.bvalid, bus.rvalid, bus.awready, bus.wready}), 64'b0010);
        do_reset("abort_clear");
        do_read(BASE + 32'd8, 0, "abort_mem");

        for (int t = 0; t < 200; t++) begin
            k = int'($urandom_range(0, 39));
            if (k >= 32) a = oor[k - 32];
            else a = BASE + 32'(4 * ((k < 16) ? k : 992 + k)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_read(a, int'($urandom_range(0, 3)), "rnd");
            else
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
